// File: rtl/sdram_refresh_scheduler.sv
// SDRAM auto-refresh scheduler: counts refresh intervals, tracks a backlog of owed
// refreshes and, once granted the command bus, issues PRECHARGE ALL followed by AUTO REFRESH commands.
module sdram_refresh_scheduler #(
  parameter int tREFI     = 780,
  parameter int tRP       = 3,
  parameter int tRFC      = 7,
  parameter int URGENT_TH = 4
) (
  input  logic        sclk,
  input  logic        sresetn,
  input  logic        iInitDone,
  input  logic        iRefEn,
  input  logic        iRef_Gnt,
  output logic        oRef_Req,
  output logic        oRef_Urgent,
  output logic        oRef_Busy,
  output logic        oRef_Done,
  output logic        oRef_Ovf,
  output logic        oCsn,
  output logic        oRasn,
  output logic        oCasn,
  output logic        oWen,
  output logic [10:0] oAddr,
  output logic [1:0]  oBank
);

  localparam int CNT_W   = (tREFI > 1) ? $clog2(tREFI) : 1;
  localparam int TMR_MAX = (tRP > tRFC) ? tRP : tRFC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // The wait states last t-1 cycles, so the timer is loaded with t-2 (tRP, tRFC >= 2).
  localparam int RP_WAIT  = (tRP > 1) ? tRP - 2 : 0;
  localparam int RFC_WAIT = (tRFC > 1) ? tRFC - 2 : 0;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(tREFI - 1);
  localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(RP_WAIT);
  localparam logic [TMR_W-1:0] RFC_LOAD = TMR_W'(RFC_WAIT);
  localparam logic [3:0]       URG_TH   = 4'(URGENT_TH);

  // {csn, rasn, casn, wen}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PRE,
    WAIT_RP,
    REF,
    WAIT_RFC,
    DONE
  } state_t;

  state_t            state_reg, next_state;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        pending_reg, pending_next;
  logic              ovf_reg, ovf_next;
  logic              urgent_reg;
  logic              req_reg, req_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [3:0]        cmd_reg, cmd_next;
  logic [10:0]       addr_reg, addr_next;
  logic              tick;
  logic              ref_dec;

  // Interval counter and backlog accounting
  always_comb begin
    cnt_next     = cnt_reg;
    tick         = 1'b0;
    pending_next = pending_reg;
    ovf_next     = ovf_reg;
    ref_dec      = (state_reg == REF);

    if (iInitDone && iRefEn) begin
      if (cnt_reg == '0) begin
        tick     = 1'b1;
        cnt_next = CNT_LOAD;
      end else begin
        cnt_next = cnt_reg - 1'b1;
      end
    end

    if (tick && !ref_dec) begin
      if (pending_reg == 3'd7) begin
        ovf_next = 1'b1;
      end else begin
        pending_next = pending_reg + 3'd1;
      end
    end else if (!tick && ref_dec) begin
      pending_next = pending_reg - 3'd1;
    end
  end

  // Sequencer next-state and command decode
  always_comb begin
    next_state = state_reg;
    timer_next = timer_reg;

    case (state_reg)
      IDLE: begin
        if (pending_reg != 3'd0) next_state = REQ;
      end
      REQ: begin
        if (iRef_Gnt) next_state = PRE;
      end
      PRE: begin
        next_state = WAIT_RP;
        timer_next = RP_LOAD;
      end
      WAIT_RP: begin
        if (timer_reg == '0) next_state = REF;
        else                 timer_next = timer_reg - 1'b1;
      end
      REF: begin
        next_state = WAIT_RFC;
        timer_next = RFC_LOAD;
      end
      WAIT_RFC: begin
        // Banks are still closed here, so a granted backlog skips the precharge.
        if (timer_reg == '0) begin
          if (pending_reg != 3'd0 && iRef_Gnt) next_state = REF;
          else                                 next_state = DONE;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    req_next  = (next_state == REQ);
    busy_next = next_state inside {PRE, WAIT_RP, REF, WAIT_RFC, DONE};
    done_next = (next_state == DONE);
    cmd_next  = CMD_DESEL;
    addr_next = 11'h000;

    case (next_state)
      PRE: begin
        cmd_next  = CMD_PRE;
        addr_next = 11'h400;
      end
      REF:                   cmd_next = CMD_REF;
      WAIT_RP, WAIT_RFC, DONE: cmd_next = CMD_NOP;
      default:               cmd_next = CMD_DESEL;
    endcase
  end

  always_ff @(posedge sclk or negedge sresetn) begin
    if (!sresetn) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      cnt_reg     <= CNT_LOAD;
      pending_reg <= 3'd0;
      ovf_reg     <= 1'b0;
      urgent_reg  <= 1'b0;
      req_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cmd_reg     <= CMD_DESEL;
      addr_reg    <= 11'h000;
    end else begin
      state_reg   <= next_state;
      timer_reg   <= timer_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
      urgent_reg  <= ({1'b0, pending_next} >= URG_TH);
      req_reg     <= req_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      cmd_reg     <= cmd_next;
      addr_reg    <= addr_next;
    end
  end

  assign oRef_Req    = req_reg;
  assign oRef_Urgent = urgent_reg;
  assign oRef_Busy   = busy_reg;
  assign oRef_Done   = done_reg;
  assign oRef_Ovf    = ovf_reg;
  assign oCsn        = cmd_reg[3];
  assign oRasn       = cmd_reg[2];
  assign oCasn       = cmd_reg[1];
  assign oWen        = cmd_reg[0];
  assign oAddr       = addr_reg;
  assign oBank       = 2'b00;

endmodule
